div32_seq: RTL and testbench

- Iterative RV32M divide/remainder sequencer built around one shared 32-bit add/sub step.
- Executes DIV, DIVU, REM and REMU with one restoring iteration per cycle.
- Sits beside the combinational ALU in the execute stage.
- Uses a valid/ready handshake on the input and output sides, so the pipeline stalls while the unit is busy.

---
 rtl/div32_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_div32_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// ---------------------------------------------------------------------------
// div32_seq -- iterative RV32M divide / remainder unit (DIV, DIVU, REM, REMU)
//
// One restoring iteration per clock around a single 33-bit subtractor.
// A request is accepted in IDLE, signs are stripped in INIT, 32 ITER cycles
// develop quotient and remainder, FIX restores the signs and DONE presents
// the selected result until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request present          in_ready   unit can accept (IDLE)
//   op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   x, y       dividend, divisor
//   flush      abort any in-flight operation (ignored in IDLE)
//   out_valid  result available         out_ready  consumer takes result
//   result     quotient (op[1]=0) or remainder (op[1]=1)
//   dz         divisor was zero, valid while out_valid=1
//
// Build option: define DIV32_EARLY_OUT_EN to finish operations with
// |x| < |y| without iterating (3-cycle latency instead of 34).
// ---------------------------------------------------------------------------
module div32_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] x,
    input  logic [XLEN-1:0] y,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            dz
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [XLEN-1:0] ZERO_C    = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_C    = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG_C = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(XLEN - 1);

    // Two's-complement negate, modulo 2^XLEN (MIN_NEG maps to itself).
    function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] v);
        neg_f = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_r;
    logic [1:0]       op_r;
    logic [XLEN-1:0]  x_r;
    logic [XLEN-1:0]  y_r;       // raw divisor until INIT, |y| afterwards
    logic [XLEN:0]    rem_r;     // partial remainder
    logic [XLEN-1:0]  q_r;       // dividend shifting out / quotient shifting in
    logic [CNT_W-1:0] cnt_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             dz_pend_r;
    logic             skip_r;    // early-out: pass through ITER without stepping
    logic             in_ready_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  result_r;
    logic             dz_r;

    logic             is_signed_s;
    logic [XLEN-1:0]  x_mag_s;
    logic [XLEN-1:0]  y_mag_s;
    logic             carry_s;
    logic [XLEN:0]    trial_s;
    logic [XLEN-1:0]  q_fix_s;
    logic [XLEN-1:0]  rem_fix_s;
    logic             unused_rem_msb_s;

    // Operand magnitudes, shared subtract step and sign fix-up values.
    always_comb begin
        is_signed_s = ~op_r[0];
        x_mag_s     = (is_signed_s && x_r[XLEN-1]) ? neg_f(x_r) : x_r;
        y_mag_s     = (is_signed_s && y_r[XLEN-1]) ? neg_f(y_r) : y_r;
        // Subtract as add of the inverted operand plus one; carry-out of 1
        // means no borrow.
        {carry_s, trial_s} = {1'b0, rem_r[XLEN-1:0], q_r[XLEN-1]}
                           + {1'b0, ~{1'b0, y_r}}
                           + {{(XLEN+1){1'b0}}, 1'b1};
        q_fix_s     = neg_q_r   ? neg_f(q_r)              : q_r;
        rem_fix_s   = neg_rem_r ? neg_f(rem_r[XLEN-1:0])  : rem_r[XLEN-1:0];
    end

    // The remainder never exceeds |y|, so its top bit only exists for the step.
    assign unused_rem_msb_s = rem_r[XLEN];

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_r        <= 2'b00;
            x_r         <= ZERO_C;
            y_r         <= ZERO_C;
            rem_r       <= {(XLEN+1){1'b0}};
            q_r         <= ZERO_C;
            cnt_r       <= {CNT_W{1'b0}};
            neg_q_r     <= 1'b0;
            neg_rem_r   <= 1'b0;
            dz_pend_r   <= 1'b0;
            skip_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= ZERO_C;
            dz_r        <= 1'b0;
        end else if (flush && (state_r != S_IDLE)) begin
            // Abort wins over a pending handoff; the result is dropped.
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        op_r       <= op;
                        x_r        <= x;
                        y_r        <= y;
                        in_ready_r <= 1'b0;
                        state_r    <= S_INIT;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end

                S_INIT: begin
                    skip_r <= 1'b0;
                    cnt_r  <= {CNT_W{1'b0}};
                    y_r    <= y_mag_s;
                    if (y_r == ZERO_C) begin
                        // Special results are parked in q/rem and FIX passes
                        // them through unchanged.
                        q_r       <= ONES_C;
                        rem_r     <= {1'b0, x_r};
                        neg_q_r   <= 1'b0;
                        neg_rem_r <= 1'b0;
                        dz_pend_r <= 1'b1;
                        state_r   <= S_FIX;
                    end else if (is_signed_s && (x_r == MIN_NEG_C) && (y_r == ONES_C)) begin
                        q_r       <= MIN_NEG_C;
                        rem_r     <= {(XLEN+1){1'b0}};
                        neg_q_r   <= 1'b0;
                        neg_rem_r <= 1'b0;
                        dz_pend_r <= 1'b0;
                        state_r   <= S_FIX;
`ifdef DIV32_EARLY_OUT_EN
                    end else if (x_mag_s < y_mag_s) begin
                        // Quotient is zero and the dividend is the remainder;
                        // one idle ITER pass keeps the latency at 3.
                        q_r       <= ZERO_C;
                        rem_r     <= {1'b0, x_mag_s};
                        neg_q_r   <= is_signed_s & (x_r[XLEN-1] ^ y_r[XLEN-1]);
                        neg_rem_r <= is_signed_s & x_r[XLEN-1];
                        dz_pend_r <= 1'b0;
                        skip_r    <= 1'b1;
                        state_r   <= S_ITER;
`endif
                    end else begin
                        q_r       <= x_mag_s;
                        rem_r     <= {(XLEN+1){1'b0}};
                        neg_q_r   <= is_signed_s & (x_r[XLEN-1] ^ y_r[XLEN-1]);
                        neg_rem_r <= is_signed_s & x_r[XLEN-1];
                        dz_pend_r <= 1'b0;
                        state_r   <= S_ITER;
                    end
                end

                S_ITER: begin
                    if (skip_r) begin
                        state_r <= S_FIX;
                    end else begin
                        if (carry_s) begin
                            rem_r <= trial_s;
                            q_r   <= {q_r[XLEN-2:0], 1'b1};
                        end else begin
                            rem_r <= {rem_r[XLEN-1:0], q_r[XLEN-1]};
                            q_r   <= {q_r[XLEN-2:0], 1'b0};
                        end
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_C) begin
                            state_r <= S_FIX;
                        end else begin
                            state_r <= S_ITER;
                        end
                    end
                end

                S_FIX: begin
                    result_r    <= op_r[1] ? rem_fix_s : q_fix_s;
                    dz_r        <= dz_pend_r;
                    out_valid_r <= 1'b1;
                    state_r     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end else begin
                        state_r     <= S_DONE;
                    end
                end

                default: begin
                    state_r     <= S_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign dz        = dz_r;

endmodule

// File: tb/tb_div32_seq.sv
// ---------------------------------------------------------------------------
// tb_div32_seq -- directed testbench for div32_seq.
// The driver issues requests and pushes hand-computed responses (result, dz,
// latency) into a scoreboard queue; an independent monitor pops and compares
// whenever out_valid rises.
// ---------------------------------------------------------------------------
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        dz;

    div32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV32_EARLY_OUT_EN
    localparam int LAT_SMALL = 3;
`else
    localparam int LAT_SMALL = 34;
`endif

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Cycle counter, stepped at every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: on each rising out_valid pop the oldest expectation and compare.
    initial begin
        logic prev_ov;
        exp_t e;
        prev_ov = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1 && !prev_ov) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", result, e.res);
                    chk("dz", {31'd0, dz}, {31'd0, e.dz});
                    chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
            end
            prev_ov = (out_valid === 1'b1);
        end
    end

    // Wait (bounded) until the unit is ready; caller sits #1 after an edge.
    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=%b required=1", in_ready);
        end
    endtask

    // Present one request and hold it until the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] r, input logic d, input int lat);
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        op = o;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            e.res = r;
            e.dz  = d;
            e.lat = lat;
            e.acc = cyc;
            sb_q.push_back(e);
        end
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic d, input int lat);
        issue(o, a, b, 1'b1, r, d, lat);
        wait_ready();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        op = 2'b00;
        x = 32'd0;
        y = 32'd0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_dz", {31'd0, dz}, 32'd0);
        rst = 1'b0;

        // Normal path, unsigned and signed.
        run(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
        run(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34);
        run(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
        run(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
        run(OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 34);
        run(OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0, 34);
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 34);
        run(OP_DIVU, 32'd5, 32'd9, 32'd0, 1'b0, LAT_SMALL);
        // Divide by zero and signed overflow.
        run(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        run(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b1, 2);
        run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2);
        run(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 2);

        // Flush during ITER cycle 10: accept edge, INIT edge, then 10 steps.
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        run(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 34);

        // Consumer stalls for 5 cycles in DONE.
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, 34);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_result", result, 32'd14);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset mid-ITER with non-reset values sitting in result/dz.
        run(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b1, 2);
        issue(OP_DIVU, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0, 0);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        run(OP_REMU, 32'd9, 32'd4, 32'd1, 1'b0, 34);

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
